glitch_pulse_gen: RTL and testbench

Clocked glitch-pulse generator driven by the event-counter trigger. After it is armed, a rising edge on `trigger_i` starts a programmed delay. The block then emits a train of pulses with programmed width, gap and count on `pulse_o`, which drives the glitch switch (crowbar/clock mux). It is the output end of the trigger path: the event counter decides *when*, this block decides *what* is emitted.

---
 rtl/glitch_pulse_gen_pkg.sv | 16 +
 rtl/sync_edge_detect.sv | 32 +++
 rtl/glitch_pulse_gen.sv | 170 +++++++++++++++++
 tb/tb_glitch_pulse_gen.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glitch_pulse_gen_pkg.sv
// Shared types and default sizes for the glitch core trigger path.
// The event counter is sized from the same GPG_WIDTH constant.
package glitch_pulse_gen_pkg;

    localparam int GPG_WIDTH  = 32;
    localparam int GPG_RWIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DELAY,
        PULSE,
        GAP
    } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// N-stage synchronizer for an asynchronous input, followed by an edge register.
// rise_o is built only from flops, so it is glitch-free and can be used directly as a clock enable.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/glitch_pulse_gen.sv
// Glitch pulse generator: arm, wait for a trigger edge, delay, then emit a pulse train.
// Outputs are registered from the current state, so pulse_o trails the PULSE state by one clock.
module glitch_pulse_gen
    import glitch_pulse_gen_pkg::*;
#(
    parameter int WIDTH       = GPG_WIDTH,
    parameter int RWIDTH      = GPG_RWIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              trigger_i,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic [WIDTH-1:0]  delay_i,
    input  logic [WIDTH-1:0]  width_i,
    input  logic [WIDTH-1:0]  gap_i,
    input  logic [RWIDTH-1:0] repeat_i,
    input  logic              polarity_i,
    output logic              pulse_o,
    output logic              armed_o,
    output logic              busy_o,
    output logic              done_o,
    output state_e            state_o
);

    logic trig_rise;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_trig_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .async_i(trigger_i),
        .rise_o (trig_rise)
    );

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [RWIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]   delay_q, delay_d, width_q, width_d, gap_q, gap_d;
    logic [RWIDTH-1:0]  rep_q, rep_d;
    logic               pol_q, pol_d;
    logic               fin_q, fin_d;
    logic               pulse_q, pulse_d;
    logic               armed_q, armed_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        delay_d = delay_q;
        width_d = width_q;
        gap_d   = gap_q;
        rep_d   = rep_q;
        pol_d   = pol_q;
        fin_d   = 1'b0;

        if (abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            rem_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // fin_q marks the cycle the last pulse is still on the pin
                    if (arm_i && !fin_q) begin
                        state_d = ARMED;
                        delay_d = delay_i;
                        width_d = (width_i == '0) ? WIDTH'(1) : width_i;
                        gap_d   = (gap_i == '0) ? WIDTH'(1) : gap_i;
                        rep_d   = (repeat_i == '0) ? RWIDTH'(1) : repeat_i;
                        pol_d   = polarity_i;
                    end
                end
                ARMED: begin
                    if (trig_rise) begin
                        rem_d = rep_q;
                        if (delay_q == '0) begin
                            state_d = PULSE;
                            cnt_d   = width_q;
                        end else begin
                            state_d = DELAY;
                            cnt_d   = delay_q;
                        end
                    end
                end
                DELAY: begin
                    if (cnt_q == WIDTH'(1)) begin
                        state_d = PULSE;
                        cnt_d   = width_q;
                    end else begin
                        cnt_d = cnt_q - WIDTH'(1);
                    end
                end
                PULSE: begin
                    if (cnt_q == WIDTH'(1)) begin
                        if (rem_q == RWIDTH'(1)) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            rem_d   = '0;
                            fin_d   = 1'b1;
                        end else begin
                            state_d = GAP;
                            cnt_d   = gap_q;
                            rem_d   = rem_q - RWIDTH'(1);
                        end
                    end else begin
                        cnt_d = cnt_q - WIDTH'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == WIDTH'(1)) begin
                        state_d = PULSE;
                        cnt_d   = width_q;
                    end else begin
                        cnt_d = cnt_q - WIDTH'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        pulse_d = pol_d ^ ((state_q == PULSE) && !abort_i);
        done_d  = fin_q && !abort_i;
        armed_d = (state_d == ARMED);
        busy_d  = !abort_i && ((state_d inside {DELAY, PULSE, GAP}) || (state_q == PULSE));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            delay_q <= '0;
            width_q <= '0;
            gap_q   <= '0;
            rep_q   <= '0;
            pol_q   <= 1'b0;
            fin_q   <= 1'b0;
            pulse_q <= 1'b0;
            armed_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            delay_q <= delay_d;
            width_q <= width_d;
            gap_q   <= gap_d;
            rep_q   <= rep_d;
            pol_q   <= pol_d;
            fin_q   <= fin_d;
            pulse_q <= pulse_d;
            armed_q <= armed_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign pulse_o = pulse_q;
    assign armed_o = armed_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Directed bench for glitch_pulse_gen: a timing-formula model checked every cycle,
// plus literal expectations at hand-computed cycles relative to the trigger edge E.
module tb_glitch_pulse_gen;
    import glitch_pulse_gen_pkg::*;

    localparam int W     = 32;
    localparam int RW    = 8;
    localparam int SS    = 2;
    localparam int NEVER = 1_000_000_000;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          trigger_i = 1'b0;
    logic          arm_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [W-1:0]  delay_i = '0;
    logic [W-1:0]  width_i = '0;
    logic [W-1:0]  gap_i = '0;
    logic [RW-1:0] repeat_i = '0;
    logic          polarity_i = 1'b0;
    logic          pulse_o, armed_o, busy_o, done_o;
    state_e        state_o;

    glitch_pulse_gen #(.WIDTH(W), .RWIDTH(RW), .SYNC_STAGES(SS)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .trigger_i (trigger_i),
        .arm_i     (arm_i),
        .abort_i   (abort_i),
        .delay_i   (delay_i),
        .width_i   (width_i),
        .gap_i     (gap_i),
        .repeat_i  (repeat_i),
        .polarity_i(polarity_i),
        .pulse_o   (pulse_o),
        .armed_o   (armed_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .state_o   (state_o)
    );

    // clock / cycle index (cyc = number of the most recent rising edge)
    always #5 clk_i = ~clk_i;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // model of the current train, in absolute edge numbers
    int m_arm, m_e, m_abort, m_d, m_w, m_g, m_r;
    bit m_pol, m_prev_pol;

    task automatic check(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: actual=%b required=%b", nm, cyc, act, exp);
        end
    endtask

    task automatic reset_model();
        m_arm = NEVER; m_e = NEVER; m_abort = NEVER;
        m_d = 0; m_w = 1; m_g = 1; m_r = 1;
        m_pol = 1'b0; m_prev_pol = 1'b0;
    endtask

    function automatic bit model_active(input int t);
        int s;
        if (m_e == NEVER) return 1'b0;
        for (int k = 0; k < m_r; k++) begin
            s = m_e + m_d + 1 + k * (m_w + m_g);
            if (t >= s && t < s + m_w) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int model_done_cyc();
        if (m_e == NEVER) return NEVER;
        return m_e + m_d + 1 + m_r * m_w + (m_r - 1) * m_g;
    endfunction

    // compare process: every cycle out of reset
    always @(negedge clk_i) begin : cmp
        int  t;
        bit  cut, pol_now;
        if (!rst_i) begin
            t       = cyc;
            cut     = (t >= m_abort);
            pol_now = (t >= m_arm) ? m_pol : m_prev_pol;
            check("mdl_armed", armed_o, !cut && t >= m_arm && t < m_e);
            check("mdl_busy",  busy_o,  !cut && m_e != NEVER && t >= m_e && t < model_done_cyc());
            check("mdl_done",  done_o,  !cut && t == model_done_cyc());
            check("mdl_pulse", pulse_o, pol_now ^ (!cut && model_active(t)));
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_until(input int c);
        @(negedge clk_i);
        while (cyc < c) @(negedge clk_i);
    endtask

    task automatic arm(input int d, input int w, input int g, input int r, input bit pol);
        delay_i    = W'(d);
        width_i    = W'(w);
        gap_i      = W'(g);
        repeat_i   = RW'(r);
        polarity_i = pol;
        arm_i      = 1'b1;
        m_prev_pol = m_pol;
        m_pol      = pol;
        m_d = d;
        m_w = (w == 0) ? 1 : w;
        m_g = (g == 0) ? 1 : g;
        m_r = (r == 0) ? 1 : r;
        m_e = NEVER; m_abort = NEVER;
        m_arm = cyc + 1;
        tick();
        arm_i      = 1'b0;
        delay_i    = $urandom;
        width_i    = $urandom;
        gap_i      = $urandom;
        repeat_i   = RW'($urandom_range(0, 255));
        polarity_i = 1'($urandom_range(0, 1));
    endtask

    task automatic trig(input bit v, input bit counts);
        trigger_i = v;
        if (counts) m_e = cyc + SS + 1;
    endtask

    task automatic settle_low();
        trigger_i = 1'b0;
        repeat (5) tick();
    endtask

    int e;

    initial begin
        reset_model();
        repeat (2) tick();
        // reset values
        check("rst_pulse", pulse_o, 1'b0);
        check("rst_armed", armed_o, 1'b0);
        check("rst_busy",  busy_o,  1'b0);
        check("rst_done",  done_o,  1'b0);
        check("rst_state", state_o == IDLE, 1'b1);
        rst_i = 1'b0;
        repeat (3) tick();

        // D=5 W=3 G=2 R=1, active high
        arm(5, 3, 2, 1, 1'b0);
        repeat (2) tick();
        trig(1'b1, 1'b1);
        e = m_e;
        wait_until(e - 1); check("s1_armed_pre", armed_o, 1'b1);
        wait_until(e);     check("s1_armed_E", armed_o, 1'b0); check("s1_busy_E", busy_o, 1'b1);
        wait_until(e + 5); check("s1_pulse_e5", pulse_o, 1'b0);
        wait_until(e + 6); check("s1_pulse_e6", pulse_o, 1'b1);
        wait_until(e + 8); check("s1_pulse_e8", pulse_o, 1'b1); check("s1_done_e8", done_o, 1'b0);
        wait_until(e + 9); check("s1_pulse_e9", pulse_o, 1'b0); check("s1_done_e9", done_o, 1'b1);
        wait_until(e + 10); check("s1_done_e10", done_o, 1'b0); check("s1_busy_e10", busy_o, 1'b0);
        tick();
        settle_low();

        // D=0 W=1 G=0 R=3
        arm(0, 1, 0, 3, 1'b0);
        tick();
        trig(1'b1, 1'b1);
        e = m_e;
        wait_until(e + 1); check("s2_p1", pulse_o, 1'b1);
        wait_until(e + 2); check("s2_g1", pulse_o, 1'b0);
        wait_until(e + 3); check("s2_p2", pulse_o, 1'b1);
        wait_until(e + 4); check("s2_g2", pulse_o, 1'b0);
        wait_until(e + 5); check("s2_p3", pulse_o, 1'b1); check("s2_nodone", done_o, 1'b0);
        wait_until(e + 6); check("s2_done", done_o, 1'b1); check("s2_end", pulse_o, 1'b0);
        tick();
        settle_low();

        // active low, W=4, R=0 treated as 1
        arm(1, 4, 7, 0, 1'b1);
        check("s3_idle_high", pulse_o, 1'b1);
        tick();
        trig(1'b1, 1'b1);
        e = m_e;
        wait_until(e + 1); check("s3_pre", pulse_o, 1'b1);
        wait_until(e + 2); check("s3_low_a", pulse_o, 1'b0);
        wait_until(e + 5); check("s3_low_b", pulse_o, 1'b0);
        wait_until(e + 6); check("s3_high", pulse_o, 1'b1); check("s3_done", done_o, 1'b1);
        tick();
        settle_low();

        // W=0 treated as 1, R=2 G=3
        arm(2, 0, 3, 2, 1'b0);
        tick();
        trig(1'b1, 1'b1);
        e = m_e;
        wait_until(e + 3); check("s3b_p1", pulse_o, 1'b1);
        wait_until(e + 4); check("s3b_g", pulse_o, 1'b0);
        wait_until(e + 7); check("s3b_p2", pulse_o, 1'b1);
        wait_until(e + 8); check("s3b_done", done_o, 1'b1);
        tick();
        settle_low();

        // edge while not armed, then a second edge during DELAY
        trig(1'b1, 1'b0);
        repeat (4) tick();
        check("s4_idle_armed", armed_o, 1'b0);
        check("s4_idle_busy", busy_o, 1'b0);
        settle_low();
        arm(8, 2, 1, 2, 1'b0);
        tick();
        trig(1'b1, 1'b1);
        e = m_e;
        wait_until(e);     trig(1'b0, 1'b0);
        wait_until(e + 3); trig(1'b1, 1'b0);
        wait_until(e + 8);  check("s4_pre", pulse_o, 1'b0);
        wait_until(e + 9);  check("s4_p1", pulse_o, 1'b1);
        wait_until(e + 11); check("s4_gap", pulse_o, 1'b0);
        wait_until(e + 12); check("s4_p2", pulse_o, 1'b1);
        wait_until(e + 14); check("s4_done", done_o, 1'b1);
        tick();
        settle_low();

        // abort beats arm in the same cycle
        arm_i = 1'b1; abort_i = 1'b1;
        tick();
        arm_i = 1'b0; abort_i = 1'b0;
        check("s5_abort_arm", armed_o, 1'b0);
        tick();

        // abort mid-PULSE, D=2 W=10
        arm(2, 10, 1, 1, 1'b0);
        tick();
        trig(1'b1, 1'b1);
        e = m_e;
        wait_until(e + 5); check("s5_in_pulse", pulse_o, 1'b1);
        abort_i = 1'b1;
        m_abort = cyc + 1;
        tick();
        abort_i = 1'b0;
        check("s5_pulse_off", pulse_o, 1'b0);
        check("s5_busy_off", busy_o, 1'b0);
        check("s5_armed_off", armed_o, 1'b0);
        check("s5_no_done", done_o, 1'b0);
        repeat (12) tick();
        settle_low();

        // re-arm after abort
        arm(1, 2, 1, 1, 1'b0);
        tick();
        trig(1'b1, 1'b1);
        e = m_e;
        wait_until(e + 2); check("s5_rearm_p", pulse_o, 1'b1);
        wait_until(e + 4); check("s5_rearm_done", done_o, 1'b1);
        tick();
        settle_low();

        // async reset mid-GAP, active low so the idle level changes
        arm(1, 3, 6, 2, 1'b1);
        tick();
        trig(1'b1, 1'b1);
        e = m_e;
        wait_until(e + 3); check("s6_low", pulse_o, 1'b0);
        wait_until(e + 6); check("s6_gap_high", pulse_o, 1'b1); check("s6_gap_busy", busy_o, 1'b1);
        #2;
        rst_i = 1'b1;
        reset_model();
        #1;
        check("s6_rst_pulse", pulse_o, 1'b0);
        check("s6_rst_busy", busy_o, 1'b0);
        check("s6_rst_armed", armed_o, 1'b0);
        check("s6_rst_done", done_o, 1'b0);
        repeat (2) tick();
        rst_i = 1'b0;
        repeat (8) tick();
        check("s6_stay_idle", state_o == IDLE, 1'b1);
        check("s6_stay_armed", armed_o, 1'b0);
        settle_low();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
